// File: rtl/card_deck_ctrl_if.sv
// Bus bundle for card_deck_ctrl: seed, shuffle, draw, card stream, insert and status.
// Handshake rule: a transfer happens on the rising edge where valid and ready are both 1;
// a requester keeps valid (and its payload) steady until it sees ready.
interface card_deck_ctrl_if #(
   parameter int CARD_W = 6,
   parameter int LFSR_W = 8,
   parameter int DW     = 3,
   parameter int AW     = 7
);
   logic              i_seed_valid;
   logic [LFSR_W-1:0] i_seed;
   logic              i_shuffle;
   logic              i_draw_valid;
   logic [DW-1:0]     i_draw_n;
   logic              o_draw_ready;
   logic              o_card_valid;
   logic [CARD_W-1:0] o_card;
   logic              i_card_ready;
   logic              o_draw_done;
   logic              o_short;
   logic              i_ins_valid;
   logic [CARD_W-1:0] i_ins_card;
   logic              o_ins_ready;
   logic [AW-1:0]     o_count;
   logic              o_empty;
   logic              o_full;
   logic              o_busy;

   modport master (
      output i_seed_valid, i_seed, i_shuffle, i_draw_valid, i_draw_n,
             i_card_ready, i_ins_valid, i_ins_card,
      input  o_draw_ready, o_card_valid, o_card, o_draw_done, o_short,
             o_ins_ready, o_count, o_empty, o_full, o_busy
   );

   modport slave (
      input  i_seed_valid, i_seed, i_shuffle, i_draw_valid, i_draw_n,
             i_card_ready, i_ins_valid, i_ins_card,
      output o_draw_ready, o_card_valid, o_card, o_draw_done, o_short,
             o_ins_ready, o_count, o_empty, o_full, o_busy
   );
endinterface

// File: rtl/card_deck_ctrl.sv
// Card pile with LFSR-driven Fisher-Yates shuffle, random-position insert and n-card draw.
// Optional macro CARD_DECK_UNO_INIT_EN: fill the pile with the 108-card UNO set after reset.
module card_deck_ctrl #(
   parameter int                CARD_W   = 6,
   parameter int                DEPTH    = 108,
   parameter int                LFSR_W   = 8,
   parameter int                MAX_DRAW = 4,
   parameter logic [LFSR_W-1:0] SEED     = 'h5A
) (
   input logic              i_clk,
   input logic              i_rst_n,
   card_deck_ctrl_if.slave  bus
);
   localparam int DW = $clog2(MAX_DRAW + 1);
   localparam int AW = $clog2(DEPTH + 1);
   localparam int RW = (AW > LFSR_W) ? AW : LFSR_W;

   typedef enum logic [2:0] {S_INIT, S_IDLE, S_SHUFFLE, S_DRAW, S_INSERT} state_t;

   function automatic logic [31:0] lfsr_taps(input int w);
      case (w)
         4:       return 32'h0000_000C;
         5:       return 32'h0000_0014;
         6:       return 32'h0000_0030;
         7:       return 32'h0000_0060;
         9:       return 32'h0000_0110;
         10:      return 32'h0000_0240;
         11:      return 32'h0000_0500;
         12:      return 32'h0000_0829;
         13:      return 32'h0000_100D;
         14:      return 32'h0000_2015;
         15:      return 32'h0000_6000;
         16:      return 32'h0000_D008;
         default: return 32'h0000_00B8;
      endcase
   endfunction

   localparam logic [LFSR_W-1:0] TAPS = LFSR_W'(lfsr_taps(LFSR_W));

`ifdef CARD_DECK_UNO_INIT_EN
   localparam int UNO_CARDS = 108;

   // Per colour (27 cards): 0, 1,1 .. 9,9, skip x2, reverse x2, draw-two x2, wild, wild-draw-four.
   function automatic logic [CARD_W-1:0] uno_card(input int idx);
      int c, p, v;
      c = idx / 27;
      p = idx % 27;
      if (p == 0)       v = 0;
      else if (p <= 24) v = (p + 1) / 2;
      else              v = p - 12;
      return CARD_W'((c << 4) | v);
   endfunction
`endif

   state_t            r_state;
   logic [CARD_W-1:0] r_mem [DEPTH];
   logic [AW-1:0]     r_count;
   logic [AW-1:0]     r_idx;
   logic [DW-1:0]     r_remain;
   logic [LFSR_W-1:0] r_lfsr;
   logic [CARD_W-1:0] r_ins_card;
   logic              r_card_valid;
   logic              r_draw_done;
   logic              r_short;

   logic [LFSR_W-1:0] w_lfsr_next;
   logic [RW-1:0]     w_k;
   logic [RW-1:0]     w_mask;
   logic [RW-1:0]     w_rand;
   logic              w_rand_ok;
   logic [AW-1:0]     w_j;
   logic              w_full;
   logic              w_draw_n_ok;
   logic              w_draw_ready;
   logic              w_ins_ready;
   logic [CARD_W-1:0] w_top;

   // Random pick in [0,k]: mask the LFSR to the next power of two and reject overshoots.
   always_comb begin
      w_k = (r_state == S_SHUFFLE) ? RW'(r_idx) : RW'(r_count);
      w_mask = w_k;
      for (int s = 0; s < RW; s++) w_mask = w_mask | (w_mask >> 1);
      w_rand    = RW'(r_lfsr) & w_mask;
      w_rand_ok = (w_rand <= w_k);
      w_j       = w_rand[AW-1:0];
   end

   always_comb begin
      if (bus.i_seed_valid)
         w_lfsr_next = (bus.i_seed == '0) ? LFSR_W'(1) : bus.i_seed;
      else
         w_lfsr_next = {r_lfsr[LFSR_W-2:0], ^(r_lfsr & TAPS)};
   end

   assign w_full       = (r_count == AW'(DEPTH));
   assign w_draw_n_ok  = (bus.i_draw_n != '0) && (int'(bus.i_draw_n) <= MAX_DRAW);
   assign w_draw_ready = (r_state == S_IDLE) && !bus.i_shuffle;
   assign w_ins_ready  = (r_state == S_IDLE) && !w_full && !bus.i_shuffle && !bus.i_draw_valid;
   assign w_top        = (r_count == '0) ? '0 : r_mem[r_count - AW'(1)];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
`ifdef CARD_DECK_UNO_INIT_EN
         r_state <= S_INIT;
`else
         r_state <= S_IDLE;
`endif
         r_count      <= '0;
         r_idx        <= '0;
         r_remain     <= '0;
         r_lfsr       <= SEED;
         r_ins_card   <= '0;
         r_card_valid <= 1'b0;
         r_draw_done  <= 1'b0;
         r_short      <= 1'b0;
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else begin
         r_lfsr      <= w_lfsr_next;
         r_draw_done <= 1'b0;
         case (r_state)
`ifdef CARD_DECK_UNO_INIT_EN
            S_INIT: begin
               for (int i = 0; i < DEPTH; i++)
                  r_mem[i] <= (i < UNO_CARDS) ? uno_card(i) : '0;
               r_count <= AW'(UNO_CARDS);
               r_state <= S_IDLE;
            end
`endif
            S_IDLE: begin
               if (bus.i_shuffle) begin
                  r_idx   <= r_count - AW'(1);
                  r_state <= S_SHUFFLE;
               end else if (bus.i_draw_valid && w_draw_n_ok) begin
                  if (r_count == '0) begin
                     r_draw_done <= 1'b1;
                     r_short     <= 1'b1;
                  end else begin
                     r_remain     <= bus.i_draw_n;
                     r_card_valid <= 1'b1;
                     r_short      <= 1'b0;
                     r_state      <= S_DRAW;
                  end
               end else if (bus.i_ins_valid && w_ins_ready) begin
                  r_ins_card <= bus.i_ins_card;
                  r_state    <= S_INSERT;
               end
            end
            S_SHUFFLE: begin
               if (r_count <= AW'(1)) begin
                  r_state <= S_IDLE;
               end else if (w_rand_ok) begin
                  r_mem[r_idx] <= r_mem[w_j];
                  r_mem[w_j]   <= r_mem[r_idx];
                  if (r_idx == AW'(1)) r_state <= S_IDLE;
                  else                 r_idx   <= r_idx - AW'(1);
               end
            end
            S_DRAW: begin
               if (bus.i_card_ready) begin
                  r_count  <= r_count - AW'(1);
                  r_remain <= r_remain - DW'(1);
                  if (r_remain == DW'(1) || r_count == AW'(1)) begin
                     r_card_valid <= 1'b0;
                     r_draw_done  <= 1'b1;
                     r_short      <= (r_remain != DW'(1));
                     r_state      <= S_IDLE;
                  end
               end
            end
            S_INSERT: begin
               if (r_count == '0) begin
                  r_mem[0] <= r_ins_card;
                  r_count  <= AW'(1);
                  r_state  <= S_IDLE;
               end else if (w_rand_ok) begin
                  // When j == count the second write wins, so the new card lands on top.
                  r_mem[r_count] <= r_mem[w_j];
                  r_mem[w_j]     <= r_ins_card;
                  r_count        <= r_count + AW'(1);
                  r_state        <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.o_draw_ready = w_draw_ready;
   assign bus.o_ins_ready  = w_ins_ready;
   assign bus.o_card_valid = r_card_valid;
   assign bus.o_card       = w_top;
   assign bus.o_draw_done  = r_draw_done;
   assign bus.o_short      = r_short;
   assign bus.o_count      = r_count;
   assign bus.o_empty      = (r_count == '0);
   assign bus.o_full       = w_full;
   assign bus.o_busy       = i_rst_n & (r_state != S_IDLE);
endmodule

// File: tb/tb_card_deck_ctrl.sv
// Directed bench for card_deck_ctrl: reset, insert, draw (full/short/empty/stalled), shuffle, full pile, reset abort.
module tb_card_deck_ctrl;
   localparam int CARD_W = 6, DEPTH = 108, LFSR_W = 8, MAX_DRAW = 4, DW = 3, AW = 7;
   typedef logic [CARD_W-1:0] card_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_cmp = 0;
   int   n_err = 0;

   card_t got_q[$];
   card_t exp_q[$];
   card_t all_q[$];
   logic  done_seen, short_seen;
   int    done_cyc;

   always #5 clk = ~clk;

   card_deck_ctrl_if #(.CARD_W(CARD_W), .LFSR_W(LFSR_W), .DW(DW), .AW(AW)) bus ();

   card_deck_ctrl #(
      .CARD_W(CARD_W), .DEPTH(DEPTH), .LFSR_W(LFSR_W), .MAX_DRAW(MAX_DRAW), .SEED(8'h5A)
   ) dut (
      .i_clk(clk), .i_rst_n(rst_n), .bus(bus)
   );

   function automatic bit same_multiset(input card_t a[$], input card_t b[$]);
      card_t x[$];
      card_t y[$];
      x = a; y = b;
      if (x.size() != y.size()) return 1'b0;
      x.sort(); y.sort();
      for (int i = 0; i < x.size(); i++) if (x[i] != y[i]) return 1'b0;
      return 1'b1;
   endfunction

   task automatic idle_inputs();
      bus.i_seed_valid = 0; bus.i_seed = '0; bus.i_shuffle = 0;
      bus.i_draw_valid = 0; bus.i_draw_n = '0; bus.i_card_ready = 1;
      bus.i_ins_valid = 0; bus.i_ins_card = '0;
   endtask

   task automatic wait_idle(input string name);
      int k = 0;
      while (bus.o_busy && k < 400) begin @(negedge clk); k++; end
      n_cmp++;
      if (bus.o_busy !== 1'b0) begin
         n_err++; $display("FAIL %s_timeout: o_busy=%b required 0", name, bus.o_busy);
      end
   endtask

   task automatic do_insert(input card_t c);
      int k = 0;
      @(negedge clk); bus.i_ins_valid = 1; bus.i_ins_card = c; #1;
      while (!bus.o_ins_ready && k < 20) begin @(negedge clk); #1; k++; end
      @(negedge clk); bus.i_ins_valid = 0;
      wait_idle("insert");
   endtask

   task automatic collect();
      int k = 0;
      done_seen = 0; short_seen = 0; done_cyc = -1;
      while (k < 40) begin
         if (bus.o_draw_done) begin done_seen = 1; short_seen = bus.o_short; done_cyc = k; break; end
         if (bus.o_card_valid && bus.i_card_ready) got_q.push_back(bus.o_card);
         @(negedge clk); k++;
      end
   endtask

   task automatic do_draw(input int n);
      got_q.delete();
      @(negedge clk); bus.i_draw_valid = 1; bus.i_draw_n = DW'(n);
      @(negedge clk); bus.i_draw_valid = 0; bus.i_draw_n = '0;
      collect();
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_n = 0;
      repeat (3) @(negedge clk);
      n_cmp++; if (bus.o_count !== 7'd0)   begin n_err++; $display("FAIL rst_count: got %0d required 0", bus.o_count); end
      n_cmp++; if (bus.o_empty !== 1'b1)   begin n_err++; $display("FAIL rst_empty: got %b required 1", bus.o_empty); end
      n_cmp++; if (bus.o_full !== 1'b0)    begin n_err++; $display("FAIL rst_full: got %b required 0", bus.o_full); end
      n_cmp++; if (bus.o_busy !== 1'b0)    begin n_err++; $display("FAIL rst_busy: got %b required 0", bus.o_busy); end
      n_cmp++; if (bus.o_card_valid !== 1'b0) begin n_err++; $display("FAIL rst_card_valid: got %b required 0", bus.o_card_valid); end
      n_cmp++; if (bus.o_draw_done !== 1'b0)  begin n_err++; $display("FAIL rst_done: got %b required 0", bus.o_draw_done); end
      n_cmp++; if (bus.o_short !== 1'b0)   begin n_err++; $display("FAIL rst_short: got %b required 0", bus.o_short); end
      n_cmp++; if (bus.o_card !== 6'h00)   begin n_err++; $display("FAIL rst_card: got %h required 00", bus.o_card); end
      rst_n = 1;
`ifdef CARD_DECK_UNO_INIT_EN
      #1;
      n_cmp++; if (bus.o_busy !== 1'b1) begin n_err++; $display("FAIL init_busy: got %b required 1", bus.o_busy); end
      @(negedge clk);
      n_cmp++; if (bus.o_count !== 7'd108) begin n_err++; $display("FAIL init_count: got %0d required 108", bus.o_count); end
      n_cmp++; if (bus.o_card !== 6'h3E)   begin n_err++; $display("FAIL init_top: got %h required 3e", bus.o_card); end
      n_cmp++; if (bus.o_busy !== 1'b0)    begin n_err++; $display("FAIL init_idle: got %b required 0", bus.o_busy); end
      n_cmp++; if (bus.o_full !== 1'b1)    begin n_err++; $display("FAIL init_full: got %b required 1", bus.o_full); end
`else
      @(negedge clk);
      n_cmp++; if (bus.o_busy !== 1'b0)       begin n_err++; $display("FAIL post_rst_busy: got %b required 0", bus.o_busy); end
      n_cmp++; if (bus.o_draw_ready !== 1'b1) begin n_err++; $display("FAIL post_rst_draw_ready: got %b required 1", bus.o_draw_ready); end
      n_cmp++; if (bus.o_ins_ready !== 1'b1)  begin n_err++; $display("FAIL post_rst_ins_ready: got %b required 1", bus.o_ins_ready); end
`endif
   endtask

`ifdef CARD_DECK_UNO_INIT_EN
   task automatic test_uno_shuffle();
      exp_q.delete(); all_q.delete();
      for (int c = 0; c < 4; c++) begin
         exp_q.push_back(card_t'(c * 16));
         for (int v = 1; v <= 12; v++) begin
            exp_q.push_back(card_t'(c * 16 + v)); exp_q.push_back(card_t'(c * 16 + v));
         end
         exp_q.push_back(card_t'(c * 16 + 13)); exp_q.push_back(card_t'(c * 16 + 14));
      end
      @(negedge clk); bus.i_seed_valid = 1; bus.i_seed = 8'h01;
      @(negedge clk); bus.i_seed_valid = 0; bus.i_shuffle = 1;
      @(negedge clk); bus.i_shuffle = 0;
      n_cmp++; if (bus.o_busy !== 1'b1) begin n_err++; $display("FAIL uno_shuf_busy: got %b required 1", bus.o_busy); end
      wait_idle("uno_shuffle");
      n_cmp++; if (bus.o_count !== 7'd108) begin n_err++; $display("FAIL uno_shuf_count: got %0d required 108", bus.o_count); end
      for (int d = 0; d < 27; d++) begin
         do_draw(4);
         foreach (got_q[i]) all_q.push_back(got_q[i]);
      end
      n_cmp++;
      if (!same_multiset(all_q, exp_q)) begin
         n_err++; $display("FAIL uno_histogram: got %0d cards differing from the 108-card set", all_q.size());
      end
      n_cmp++; if (bus.o_empty !== 1'b1) begin n_err++; $display("FAIL uno_drained: got empty=%b required 1", bus.o_empty); end
   endtask
`endif

   task automatic test_insert_pair();
      do_insert(6'h05);
      n_cmp++; if (bus.o_count !== 7'd1) begin n_err++; $display("FAIL ins1_count: got %0d required 1", bus.o_count); end
      n_cmp++; if (bus.o_card !== 6'h05) begin n_err++; $display("FAIL ins1_top: got %h required 05", bus.o_card); end
      do_insert(6'h1A);
      n_cmp++; if (bus.o_count !== 7'd2) begin n_err++; $display("FAIL ins2_count: got %0d required 2", bus.o_count); end
      n_cmp++;
      if (bus.o_card !== 6'h05 && bus.o_card !== 6'h1A) begin
         n_err++; $display("FAIL ins2_top: got %h required 05 or 1a", bus.o_card);
      end
      do_draw(2);
      exp_q = '{6'h05, 6'h1A};
      n_cmp++; if (!same_multiset(got_q, exp_q)) begin n_err++; $display("FAIL pair_cards: got %p required %p", got_q, exp_q); end
      n_cmp++; if (done_seen !== 1'b1 || done_cyc != 2) begin n_err++; $display("FAIL pair_done: got seen=%b cyc=%0d required 1/2", done_seen, done_cyc); end
      n_cmp++; if (short_seen !== 1'b0) begin n_err++; $display("FAIL pair_short: got %b required 0", short_seen); end
      n_cmp++; if (bus.o_empty !== 1'b1) begin n_err++; $display("FAIL pair_empty: got %b required 1", bus.o_empty); end
   endtask

   task automatic test_short_draw();
      do_insert(6'h11); do_insert(6'h12); do_insert(6'h13);
      n_cmp++; if (bus.o_count !== 7'd3) begin n_err++; $display("FAIL short_fill: got %0d required 3", bus.o_count); end
      do_draw(4);
      exp_q = '{6'h11, 6'h12, 6'h13};
      n_cmp++; if (!same_multiset(got_q, exp_q)) begin n_err++; $display("FAIL short_cards: got %p required %p", got_q, exp_q); end
      n_cmp++; if (done_seen !== 1'b1 || done_cyc != 3) begin n_err++; $display("FAIL short_done: got seen=%b cyc=%0d required 1/3", done_seen, done_cyc); end
      n_cmp++; if (short_seen !== 1'b1) begin n_err++; $display("FAIL short_flag: got %b required 1", short_seen); end
      n_cmp++; if (bus.o_empty !== 1'b1 || bus.o_count !== 7'd0) begin n_err++; $display("FAIL short_empty: got empty=%b count=%0d required 1/0", bus.o_empty, bus.o_count); end
   endtask

   task automatic test_empty_and_bad_n();
      do_draw(2);
      n_cmp++; if (done_seen !== 1'b1 || done_cyc != 0) begin n_err++; $display("FAIL empty_done: got seen=%b cyc=%0d required 1/0", done_seen, done_cyc); end
      n_cmp++; if (short_seen !== 1'b1) begin n_err++; $display("FAIL empty_short: got %b required 1", short_seen); end
      n_cmp++; if (got_q.size() != 0) begin n_err++; $display("FAIL empty_cards: got %0d cards required 0", got_q.size()); end
      do_insert(6'h07);
      do_draw(0);
      n_cmp++; if (done_seen !== 1'b0 || bus.o_count !== 7'd1) begin n_err++; $display("FAIL draw_n0: got done=%b count=%0d required 0/1", done_seen, bus.o_count); end
      do_draw(5);
      n_cmp++; if (done_seen !== 1'b0 || bus.o_count !== 7'd1) begin n_err++; $display("FAIL draw_n5: got done=%b count=%0d required 0/1", done_seen, bus.o_count); end
      do_draw(1);
      n_cmp++; if (got_q.size() != 1 || got_q[0] !== 6'h07) begin n_err++; $display("FAIL draw_n1_card: got %p required '{07}", got_q); end
      n_cmp++; if (done_seen !== 1'b1 || short_seen !== 1'b0 || done_cyc != 1) begin n_err++; $display("FAIL draw_n1_done: got done=%b short=%b cyc=%0d required 1/0/1", done_seen, short_seen, done_cyc); end
   endtask

   task automatic test_stall();
      card_t first;
      do_insert(6'h21); do_insert(6'h22); do_insert(6'h23);
      bus.i_card_ready = 0;
      got_q.delete();
      @(negedge clk); bus.i_draw_valid = 1; bus.i_draw_n = 3'd2;
      @(negedge clk); bus.i_draw_valid = 0; bus.i_draw_n = '0;
      first = bus.o_card;
      n_cmp++; if (first !== 6'h21 && first !== 6'h22 && first !== 6'h23) begin n_err++; $display("FAIL stall_first: got %h required 21/22/23", first); end
      for (int i = 0; i < 5; i++) begin
         n_cmp++; if (bus.o_card_valid !== 1'b1) begin n_err++; $display("FAIL stall_valid[%0d]: got %b required 1", i, bus.o_card_valid); end
         n_cmp++; if (bus.o_card !== first) begin n_err++; $display("FAIL stall_card[%0d]: got %h required %h", i, bus.o_card, first); end
         n_cmp++; if (bus.o_count !== 7'd3) begin n_err++; $display("FAIL stall_count[%0d]: got %0d required 3", i, bus.o_count); end
         @(negedge clk);
      end
      bus.i_card_ready = 1;
      collect();
      all_q = got_q;
      n_cmp++; if (got_q.size() != 2 || got_q[0] !== first) begin n_err++; $display("FAIL stall_cards: got %p required 2 cards starting %h", got_q, first); end
      n_cmp++; if (done_seen !== 1'b1 || short_seen !== 1'b0 || bus.o_count !== 7'd1) begin n_err++; $display("FAIL stall_done: got done=%b short=%b count=%0d required 1/0/1", done_seen, short_seen, bus.o_count); end
      do_draw(1);
      all_q.push_back(got_q.size() > 0 ? got_q[0] : 6'h00);
      exp_q = '{6'h21, 6'h22, 6'h23};
      n_cmp++; if (!same_multiset(all_q, exp_q)) begin n_err++; $display("FAIL stall_all: got %p required %p", all_q, exp_q); end
   endtask

   task automatic test_shuffle();
      exp_q.delete(); all_q.delete();
      for (int i = 0; i < 6; i++) begin
         do_insert(card_t'(8'h30 + i)); exp_q.push_back(card_t'(8'h30 + i));
      end
      @(negedge clk); bus.i_seed_valid = 1; bus.i_seed = 8'h01;
      @(negedge clk); bus.i_seed_valid = 0; bus.i_shuffle = 1;
      @(negedge clk); bus.i_shuffle = 0;
      n_cmp++; if (bus.o_busy !== 1'b1) begin n_err++; $display("FAIL shuf_busy: got %b required 1", bus.o_busy); end
      n_cmp++; if (bus.o_draw_ready !== 1'b0 || bus.o_ins_ready !== 1'b0) begin n_err++; $display("FAIL shuf_readies: got draw=%b ins=%b required 0/0", bus.o_draw_ready, bus.o_ins_ready); end
      wait_idle("shuffle");
      n_cmp++; if (bus.o_count !== 7'd6) begin n_err++; $display("FAIL shuf_count: got %0d required 6", bus.o_count); end
      do_draw(4); foreach (got_q[i]) all_q.push_back(got_q[i]);
      do_draw(2); foreach (got_q[i]) all_q.push_back(got_q[i]);
      n_cmp++; if (!same_multiset(all_q, exp_q)) begin n_err++; $display("FAIL shuf_cards: got %p required %p", all_q, exp_q); end
      do_insert(6'h3F);
      @(negedge clk); bus.i_shuffle = 1;
      @(negedge clk); bus.i_shuffle = 0;
      n_cmp++; if (bus.o_busy !== 1'b1) begin n_err++; $display("FAIL shuf1_busy: got %b required 1", bus.o_busy); end
      @(negedge clk);
      n_cmp++; if (bus.o_busy !== 1'b0) begin n_err++; $display("FAIL shuf1_done: got %b required 0", bus.o_busy); end
      n_cmp++; if (bus.o_card !== 6'h3F || bus.o_count !== 7'd1) begin n_err++; $display("FAIL shuf1_pile: got %h/%0d required 3f/1", bus.o_card, bus.o_count); end
      do_draw(1);
   endtask

   task automatic test_full();
      for (int i = 0; i < DEPTH; i++) do_insert(card_t'(i));
      n_cmp++; if (bus.o_count !== 7'd108) begin n_err++; $display("FAIL full_count: got %0d required 108", bus.o_count); end
      n_cmp++; if (bus.o_full !== 1'b1 || bus.o_empty !== 1'b0) begin n_err++; $display("FAIL full_flags: got full=%b empty=%b required 1/0", bus.o_full, bus.o_empty); end
      n_cmp++; if (bus.o_ins_ready !== 1'b0) begin n_err++; $display("FAIL full_ins_ready: got %b required 0", bus.o_ins_ready); end
      @(negedge clk); bus.i_ins_valid = 1; bus.i_ins_card = 6'h2A;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_cmp++; if (bus.o_busy !== 1'b0) begin n_err++; $display("FAIL full_ignore_busy[%0d]: got %b required 0", i, bus.o_busy); end
      end
      bus.i_ins_valid = 0;
      @(negedge clk);
      n_cmp++; if (bus.o_count !== 7'd108) begin n_err++; $display("FAIL full_ignore_count: got %0d required 108", bus.o_count); end
   endtask

   task automatic test_reset_mid_shuffle();
      @(negedge clk); bus.i_shuffle = 1;
      @(negedge clk); bus.i_shuffle = 0;
      repeat (4) @(negedge clk);
      n_cmp++; if (bus.o_busy !== 1'b1) begin n_err++; $display("FAIL mid_busy: got %b required 1", bus.o_busy); end
      #2 rst_n = 0;
      @(negedge clk);
      n_cmp++; if (bus.o_busy !== 1'b0)      begin n_err++; $display("FAIL abort_busy: got %b required 0", bus.o_busy); end
      n_cmp++; if (bus.o_draw_done !== 1'b0) begin n_err++; $display("FAIL abort_done: got %b required 0", bus.o_draw_done); end
      n_cmp++; if (bus.o_count !== 7'd0)     begin n_err++; $display("FAIL abort_count: got %0d required 0", bus.o_count); end
      rst_n = 1;
      @(negedge clk);
`ifdef CARD_DECK_UNO_INIT_EN
      n_cmp++; if (bus.o_count !== 7'd108 || bus.o_card !== 6'h3E) begin n_err++; $display("FAIL reinit: got %0d/%h required 108/3e", bus.o_count, bus.o_card); end
`else
      n_cmp++; if (bus.o_count !== 7'd0 || bus.o_busy !== 1'b0) begin n_err++; $display("FAIL post_abort: got count=%0d busy=%b required 0/0", bus.o_count, bus.o_busy); end
`endif
   endtask

   initial begin
      test_reset();
`ifdef CARD_DECK_UNO_INIT_EN
      test_uno_shuffle();
`endif
      test_insert_pair();
      test_short_draw();
      test_empty_and_bad_n();
      test_stall();
      test_shuffle();
      test_full();
      test_reset_mid_shuffle();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/card_deck_ctrl.md
CARD_DECK_CTRL -- requirements
Module: card_deck_ctrl

Interface
REQ-001 SHALL have parameter CARD_W, 6, card code width ({color[1:0], value[3:0]} at default).
REQ-002 SHALL have parameter DEPTH, 108, pile capacity in cards.
REQ-003 SHALL have parameter LFSR_W, 8, random generator width; 2**LFSR_W >= DEPTH is required.
REQ-004 SHALL have parameter MAX_DRAW, 4, largest cards per draw request; DW = $clog2(MAX_DRAW+1), AW = $clog2(DEPTH+1).
REQ-005 SHALL have parameter SEED, 8'h5A, nonzero LFSR reset value.
REQ-006 Ports: i_clk  in  1  clock; i_rst_n  in  1  reset, asynchronous, active-low (clock is i_clk).
REQ-007 Ports: i_seed_valid  in  1  load seed; i_seed  in  LFSR_W  seed value.
REQ-008 Ports: i_shuffle  in  1  shuffle request pulse.
REQ-009 Ports: i_draw_valid  in  1; i_draw_n  in  DW  cards requested; o_draw_ready  out  1.
REQ-010 Ports: o_card_valid  out  1; o_card  out  CARD_W  top card; i_card_ready  in  1.
REQ-011 Ports: o_draw_done  out  1  one-cycle pulse; o_short  out  1  pile emptied before n cards, valid with o_draw_done.
REQ-012 Ports: i_ins_valid  in  1; i_ins_card  in  CARD_W; o_ins_ready  out  1.
REQ-013 Ports: o_count  out  AW  cards held; o_empty  out  1; o_full  out  1; o_busy  out  1  (state != IDLE).

Function
REQ-014 States SHALL be INIT, IDLE, SHUFFLE, DRAW, INSERT; INIT exists only per REQ-030.
REQ-015 LFSR SHALL be maximal-length Fibonacci, advance every cycle, load i_seed on i_seed_valid; a zero seed loads 1.
REQ-016 Random index in [0,k]: use lfsr mod 2**ceil(log2(k+1)); if value > k, reject and retry next cycle.
REQ-017 IDLE priority SHALL be i_shuffle > draw > insert; o_draw_ready = IDLE & !i_shuffle; o_ins_ready = IDLE & !full & !i_shuffle & !i_draw_valid.
REQ-018 SHUFFLE: i from count-1 down to 1, pick j in [0,i], swap mem[i]/mem[j], decrement i; after i==1 return to IDLE.
REQ-019 SHUFFLE with count <= 1 SHALL return to IDLE next cycle, pile unchanged.
REQ-020 Draw accepted on i_draw_valid & o_draw_ready with i_draw_n>0; i_draw_n==0 or >MAX_DRAW ignored, no done pulse.
REQ-021 DRAW: o_card_valid=1 with o_card=mem[count-1] while count>0; each i_card_ready handshake decrements count by one.
REQ-022 DRAW ends after n handshakes or when count reaches 0; o_draw_done pulses in the cycle after the last handshake, o_short=1 if fewer than n delivered.
REQ-023 Draw accepted with count==0 SHALL pulse o_draw_done, o_short=1 next cycle with no card.
REQ-024 INSERT: count==0 writes mem[0]; else pick j in [0,count], mem[count]<=mem[j], mem[j]<=card; count increments; return to IDLE.
REQ-025 i_ins_valid while o_full SHALL be ignored; count never exceeds DEPTH nor wraps below 0.
REQ-026 o_card_valid SHALL be 0 outside DRAW; o_card holds mem[count-1] (0 when empty) at all times.
REQ-027 Requests arriving while busy SHALL be ignored; the requester holds valid until ready.

Reset
REQ-028 On reset: state INIT (macro on) else IDLE; count 0; memory 0; lfsr=SEED; all valid/done/short/busy outputs 0, o_empty 1.
REQ-029 Reset mid-operation SHALL abort immediately; no partial draw_done is emitted.

Configuration
REQ-030 Macro CARD_DECK_UNO_INIT_EN defined: INIT writes the standard 108-card set (per color: one 0, two each 1-9, skip, reverse, draw-two, one wild, one wild-draw-four) into mem[0..107] in color order, count=108, one cycle, then IDLE; requires DEPTH>=108. Undefined: no INIT, pile empty after reset, filled only via insert.

Verification
REQ-031 Macro on, reset release -> one INIT cycle, then o_count=108, o_card=6'h3E (blue wild draw four), o_busy=0.
REQ-032 Macro on, seed 8'h01, i_shuffle -> o_busy until done, o_count=108, per-code histogram unchanged.
REQ-033 count=3, draw n=4, i_card_ready=1 -> 3 cards, o_draw_done=1, o_short=1, o_empty=1.
REQ-034 Macro off, insert 6'h05 then 6'h1A -> o_count=2, both codes present, drawing 2 returns exactly {05,1A}.
REQ-035 Draw n=2 with i_card_ready held low 5 cycles -> o_card_valid stays 1, o_card stable, count unchanged until ready.
REQ-036 Assert i_rst_n low mid-SHUFFLE -> next cycle o_busy=0 (macro off) or INIT (macro on), o_draw_done=0.
